// File: rtl/i4_sched_pkg.sv
// Shared types and constants for the priority-group interrupt scheduler.
package i4_sched_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SERVICE = 2'd2
    } sched_state_e;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i4_rr_pick.sv
// Round-robin picker: first set bit of elig at or above start, wrapping to 0.
module i4_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   start,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(start) + k) % NREQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/i4_irq_sched.sv
// Interrupt scheduler: edge-captured pending groups, maskable, round-robin
// grant with ready handshake and an optional service timeout.
module i4_irq_sched
    import i4_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TO_W = 8,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            mask_we,
    input  logic [NREQ-1:0] mask_wdata,
    input  logic [TO_W-1:0] timeout_cycles,
    input  logic            eoi,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_id,
    output logic            busy,
    output logic [NREQ-1:0] pend_o,
    output logic [NREQ-1:0] mask_o,
    output logic            timeout_err
);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("i4_irq_sched: NREQ out of range");
    end

    sched_state_e    state, state_n;
    logic [NREQ-1:0] req_q, pend, mask, rise, clr, elig;
    logic [TO_W-1:0] cnt;
    logic [IW-1:0]   last_ptr, gnt_id_q, start, pick_idx;
    logic            pick_found, accept, timeout_hit, terr_q;

    assign rise   = req_i & ~req_q;
    assign elig   = pend & ~mask;
    assign start  = IW'(wrap_inc(int'(last_ptr), NREQ));
    assign accept = (state == ST_GRANT) && gnt_ready;
    assign clr    = accept ? (NREQ'(1) << gnt_id_q) : '0;

    // eoi takes priority over the limit, so the limit only fires without it
    assign timeout_hit = (state == ST_SERVICE) && !eoi && (timeout_cycles != '0) &&
                         (cnt == timeout_cycles - TO_W'(1));

    i4_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .elig  (elig),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (pick_found)          state_n = ST_GRANT;
            ST_GRANT:   if (gnt_ready)           state_n = ST_SERVICE;
            ST_SERVICE: if (eoi || timeout_hit)  state_n = ST_IDLE;
            default:                             state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_valid = (state == ST_GRANT);
        busy      = (state == ST_GRANT) || (state == ST_SERVICE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            pend     <= '0;
            mask     <= '0;
            cnt      <= '0;
            last_ptr <= IW'(NREQ - 1);
            gnt_id_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            req_q  <= req_i;
            pend   <= (pend & ~clr) | rise;
            terr_q <= timeout_hit;
            if (mask_we)
                mask <= mask_wdata;
            if (state == ST_IDLE && pick_found)
                gnt_id_q <= pick_idx;
            if (accept) begin
                last_ptr <= gnt_id_q;
                cnt      <= '0;
            end else if (state == ST_SERVICE) begin
                cnt <= cnt + TO_W'(1);
            end
        end
    end

    assign gnt_id      = gnt_id_q;
    assign pend_o      = pend;
    assign mask_o      = mask;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_i4_irq_sched.sv
// Bench for i4_irq_sched: behavioural model compared every cycle plus
// directed scenarios with literal expectations.
module tb_i4_irq_sched;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_i, mask_wdata;
    logic          mask_we, eoi, gnt_ready;
    logic [TW-1:0] timeout_cycles;
    logic          gnt_valid, busy, timeout_err;
    logic [IW-1:0] gnt_id;
    logic [N-1:0]  pend_o, mask_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i4_irq_sched #(.NREQ(N), .TO_W(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .mask_we        (mask_we),
        .mask_wdata     (mask_wdata),
        .timeout_cycles (timeout_cycles),
        .eoi            (eoi),
        .gnt_ready      (gnt_ready),
        .gnt_valid      (gnt_valid),
        .gnt_id         (gnt_id),
        .busy           (busy),
        .pend_o         (pend_o),
        .mask_o         (mask_o),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // granting: a grant is on offer; serving: accepted, awaiting eoi/timeout;
    // served: cycles spent in service since acceptance.
    logic [N-1:0] m_pend, m_mask, m_reqq, n_pend, n_mask, m_clr, m_elig;
    int           m_last, m_id, m_served, n_last, n_id, n_served;
    bit           m_granting, m_serving, m_terr, n_granting, n_serving, n_terr, m_hit;

    always_comb begin
        n_last     = m_last;
        n_id       = m_id;
        n_served   = m_served;
        n_granting = m_granting;
        n_serving  = m_serving;
        n_terr     = 1'b0;
        m_clr      = '0;
        m_hit      = 1'b0;
        m_elig     = m_pend & ~m_mask;
        if (m_serving) begin
            if (eoi) n_serving = 1'b0;
            else if (timeout_cycles != 0 && m_served + 1 == int'(timeout_cycles)) begin
                n_terr    = 1'b1;
                n_serving = 1'b0;
            end else n_served = m_served + 1;
        end else if (m_granting) begin
            if (gnt_ready) begin
                m_clr      = N'(1) << m_id;
                n_last     = m_id;
                n_served   = 0;
                n_granting = 1'b0;
                n_serving  = 1'b1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!m_hit && ((m_elig >> ((m_last + k) % N)) & N'(1)) != 0) begin
                    m_hit = 1'b1;
                    n_id  = (m_last + k) % N;
                end
            end
            if (m_hit) n_granting = 1'b1;
        end
        n_pend = (m_pend & ~m_clr) | (req_i & ~m_reqq);
        n_mask = mask_we ? mask_wdata : m_mask;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= '0; m_mask <= '0; m_reqq <= '0;
            m_last <= N - 1; m_id <= 0; m_served <= 0;
            m_granting <= 1'b0; m_serving <= 1'b0; m_terr <= 1'b0;
        end else begin
            m_pend <= n_pend; m_mask <= n_mask; m_reqq <= req_i;
            m_last <= n_last; m_id <= n_id; m_served <= n_served;
            m_granting <= n_granting; m_serving <= n_serving; m_terr <= n_terr;
        end
    end

    always @(negedge clk) begin
        chk("mdl gnt_valid",   gnt_valid,   m_granting);
        chk("mdl gnt_id",      gnt_id,      m_id);
        chk("mdl busy",        busy,        m_granting | m_serving);
        chk("mdl pend_o",      pend_o,      m_pend);
        chk("mdl mask_o",      mask_o,      m_mask);
        chk("mdl timeout_err", timeout_err, m_terr);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise_req(input logic [N-1:0] v);
        req_i = '0;
        tick(1);
        req_i = v;
    endtask

    task automatic wait_grant(input int exp_id, input string nm);
        int k;
        k = 0;
        while (gnt_valid !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        chk({nm, " valid"}, gnt_valid, 1);
        chk({nm, " id"}, gnt_id, exp_id);
    endtask

    task automatic accept();
        gnt_ready = 1'b1;
        tick(1);
        gnt_ready = 1'b0;
    endtask

    task automatic serve();
        accept();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we = 1'b1; mask_wdata = v;
        tick(1);
        mask_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_i = '0; mask_we = 1'b0; mask_wdata = '0;
        eoi = 1'b0; gnt_ready = 1'b0; timeout_cycles = '0;
        tick(2);
        chk("rst gnt_valid", gnt_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst pend", pend_o, 0);
        chk("rst gnt_id", gnt_id, 0);
        chk("rst terr", timeout_err, 0);
        rst_n = 1'b1;
        tick(1);

        // single request: two-edge latency, eoi/mask ignored while granting
        rise_req(4'b0100);
        tick(1);
        chk("lat pend", pend_o, 4'b0100);
        chk("lat valid0", gnt_valid, 0);
        tick(1);
        chk("lat valid1", gnt_valid, 1);
        chk("lat id", gnt_id, 2);
        eoi = 1'b1; tick(1); eoi = 1'b0;
        chk("eoi in grant", gnt_valid, 1);
        write_mask(4'b0100);
        chk("mask in grant valid", gnt_valid, 1);
        chk("mask in grant id", gnt_id, 2);
        accept();
        chk("acc pend", pend_o, 0);
        chk("acc busy", busy, 1);
        chk("acc valid", gnt_valid, 0);
        eoi = 1'b1; tick(1); eoi = 1'b0;
        chk("eoi busy", busy, 0);
        write_mask(4'b0000);

        // all four at once from reset: 0,1,2,3
        do_reset();
        req_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_grant(i, "order");
            serve();
        end

        // last=3, pend 1001 -> wraps to 0 then 3
        rise_req(4'b1001);
        wait_grant(0, "wrap0");
        chk("wrap pend", pend_o, 4'b1001);
        serve();
        wait_grant(3, "wrap3");
        serve();

        // masked group 0 waits until unmasked
        write_mask(4'b0001);
        rise_req(4'b0011);
        wait_grant(1, "mask1");
        serve();
        tick(3);
        chk("masked idle", gnt_valid, 0);
        chk("masked pend", pend_o, 4'b0001);
        write_mask(4'b0000);
        wait_grant(0, "unmask0");
        serve();

        // timeout of 5: pulse exactly 5 edges after acceptance
        timeout_cycles = 8'd5;
        rise_req(4'b0100);
        wait_grant(2, "to grant");
        accept();
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("to early", timeout_err, 0);
            chk("to busy", busy, 1);
        end
        tick(1);
        chk("to pulse", timeout_err, 1);
        chk("to idle", busy, 0);
        tick(1);
        chk("to pulse end", timeout_err, 0);

        // eoi on the timeout cycle wins
        rise_req(4'b0100);
        wait_grant(2, "to2 grant");
        accept();
        tick(4);
        eoi = 1'b1; tick(1); eoi = 1'b0;
        chk("eoi wins terr", timeout_err, 0);
        chk("eoi wins idle", busy, 0);
        tick(1);
        chk("eoi wins terr2", timeout_err, 0);

        // timeout 0 disables the limit even past counter wrap
        timeout_cycles = 8'd0;
        rise_req(4'b0010);
        wait_grant(1, "nolimit grant");
        accept();
        tick(260);
        chk("nolimit busy", busy, 1);
        eoi = 1'b1; tick(1); eoi = 1'b0;

        // reset in SERVICE: outputs go to reset values immediately
        write_mask(4'b1000);
        rise_req(4'b0100);
        wait_grant(2, "rst grant");
        accept();
        req_i = 4'b0110;
        tick(1);
        chk("pre-rst pend", pend_o, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("async gnt_valid", gnt_valid, 0);
        chk("async busy", busy, 0);
        chk("async pend", pend_o, 0);
        chk("async mask", mask_o, 0);
        chk("async gnt_id", gnt_id, 0);
        chk("async terr", timeout_err, 0);
        req_i = '0;
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i4_irq_sched.md
I4_IRQ_SCHED -- requirements
Module: i4_irq_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of priority-group request lines; legal range is 2..8.
REQ-002 SHALL have parameter TO_W, default 8, giving the width of the service-timeout counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_i  input  NREQ  level request per group; active high.
REQ-006 SHALL have port mask_we  input  1  mask write strobe.
REQ-007 SHALL have port mask_wdata  input  NREQ  new mask value; bit=1 blocks that group.
REQ-008 SHALL have port timeout_cycles  input  TO_W  service limit in cycles; value 0 disables the limit.
REQ-009 SHALL have port eoi  input  1  end-of-service pulse from the servicing agent.
REQ-010 SHALL have port gnt_ready  input  1  consumer accepts the grant.
REQ-011 SHALL have port gnt_valid  output  1  grant offered.
REQ-012 SHALL have port gnt_id  output  clog2(NREQ)  granted group index.
REQ-013 SHALL have port busy  output  1  high in GRANT and SERVICE states.
REQ-014 SHALL have port pend_o  output  NREQ  pending vector.
REQ-015 SHALL have port mask_o  output  NREQ  current mask.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse on service timeout.

Function
REQ-017 SHALL register req_i into req_q each cycle; rise = req_i & ~req_q.
REQ-018 SHALL set pend[i] on rise[i]; SHALL clear pend[i] on grant acceptance of i; set wins on a same-cycle set and clear.
REQ-019 SHALL update mask on mask_we at the next edge; eligible = pend & ~mask.
REQ-020 SHALL implement states IDLE, GRANT, SERVICE.
REQ-021 IDLE: if eligible != 0, SHALL latch gnt_id = first eligible index searching upward from last_ptr+1 modulo NREQ, wrapping past NREQ-1 to 0, and go to GRANT.
REQ-022 GRANT: gnt_valid SHALL be 1; gnt_id SHALL stay stable; the grant SHALL NOT be withdrawn, including when the mask changes.
REQ-023 GRANT with gnt_ready=1: SHALL clear pend[gnt_id], set last_ptr = gnt_id, clear the counter, and go to SERVICE.
REQ-024 SERVICE: SHALL increment the counter each cycle; on eoi=1 SHALL go to IDLE.
REQ-025 SERVICE with timeout_cycles != 0 and counter = timeout_cycles-1 and eoi=0: SHALL pulse timeout_err for 1 cycle and go to IDLE.
REQ-026 eoi and a timeout in the same cycle: eoi SHALL win and timeout_err SHALL stay 0.
REQ-027 SHALL ignore eoi outside SERVICE.
REQ-028 Latency: req_i rising before edge k SHALL give gnt_valid=1 after edge k+1, from IDLE.
REQ-029 gnt_valid SHALL be 0 in IDLE and SERVICE; gnt_id SHALL hold its last value outside GRANT.

Reset
REQ-030 On rst_n=0: state=IDLE, pend=0, req_q=0, mask=0, counter=0, last_ptr=NREQ-1, gnt_id=0, gnt_valid=0, busy=0, timeout_err=0.
REQ-031 Reset mid-GRANT or mid-SERVICE SHALL abandon the grant with no timeout_err.

Structure
REQ-032 SHALL define the state enum and the constant NREQ_MAX=8 in package i4_sched_pkg.
REQ-033 SHALL contain one combinational sub-module, i4_rr_pick (eligible vector plus start index in, index and found flag out).

Verification
REQ-034 Reset, then req_i=4'b0100 -> gnt_valid=1 with gnt_id=2 two cycles later; gnt_ready=1 -> pend_o=0, busy=1; eoi -> IDLE, busy=0.
REQ-035 req_i=4'b1111 at once, immediate ready and eoi each time -> grant order 0,1,2,3.
REQ-036 last grant=3, pend=4'b1001 -> next grant=0 (wrap).
REQ-037 mask=4'b0001, req 0 and 1 -> grant 1 only; unmask -> grant 0 follows.
REQ-038 timeout_cycles=5, no eoi -> timeout_err pulses exactly 5 cycles after acceptance, then IDLE; eoi on that cycle -> no pulse.
REQ-039 rst_n low during SERVICE -> all outputs at reset values on the same cycle.
